// File: rtl/clk_domain_pkg.sv
// Package for the clock-domain controller.
// Provides the reset-sequencing state type and default parameter values.
// Optional feature macro: CLK_DOMAIN_CTRL_STEP_EN.
// When it is defined, paused channels accept single-step requests.
package clk_domain_pkg;

    // Reset sequencing states:
    //   S_ASSERT : reset held, waiting for the synchronised release
    //   S_HOLD   : stretched sync_rst with all clock enables forced on
    //   S_RUN    : normal operation
    typedef enum logic [1:0] {
        S_ASSERT = 2'd0,
        S_HOLD   = 2'd1,
        S_RUN    = 2'd2
    } rst_state_t;

    localparam int DEF_NUM_CH          = 2;
    localparam int DEF_DIV_W           = 16;
    localparam int DEF_RST_SYNC_STAGES = 2;
    localparam int DEF_RST_HOLD_CYCLES = 16;

    // Returns the counter width needed to hold values 0..n-1 (at least 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// One clock-enable channel: a down-counter that reloads from div and
// produces one enable pulse every div+1 running cycles.
// Optional feature macro: CLK_DOMAIN_CTRL_STEP_EN (adds the step input).
// Ports:
//   clk, async_rst : reference clock, asynchronous active-low clear
//   force_on       : the controller enters or stays in reset hold next cycle
//   active         : the controller is in run and stays in run
//   run            : channel run (1) / pause (0)
//   div            : divide value D, period D+1
//   step           : (feature) one pulse per cycle while paused
//   clk_en         : registered enable pulse
module clk_en_divider
    import clk_domain_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic             force_on,
    input  logic             active,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
`ifdef CLK_DOMAIN_CTRL_STEP_EN
    input  logic             step,
`endif
    output logic             clk_en
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            cnt    <= '0;
            clk_en <= 1'b0;
        end else if (force_on) begin
            // Gated flops behind this enable must see edges during reset hold.
            cnt    <= '0;
            clk_en <= 1'b1;
        end else if (!active) begin
            // Covers the reset-assert state and the edge that enters run,
            // so every run period starts from a cleared counter.
            cnt    <= '0;
            clk_en <= 1'b0;
        end else if (run) begin
            if (cnt == '0) begin
                clk_en <= 1'b1;
                cnt    <= div;
            end else begin
                clk_en <= 1'b0;
                cnt    <= cnt - 1'b1;
            end
        end else begin
            // Paused: counter holds so the phase resumes where it stopped.
`ifdef CLK_DOMAIN_CTRL_STEP_EN
            clk_en <= step;
`else
            clk_en <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/clk_domain_ctrl.sv
// Clock-domain controller: synchronises the board reset release, stretches
// a synchronous reset for downstream logic, and drives NUM_CH programmable
// clock-enable channels.
// Optional feature macro: CLK_DOMAIN_CTRL_STEP_EN (adds step_req).
// Ports:
//   clk          : free-running reference clock
//   async_rst    : asynchronous active-low reset (release synchronised)
//   soft_rst_req : restarts the reset-hold sequence from hold or run
//   ch_run       : per-channel run/pause
//   ch_div       : per-channel divide value D (period D+1)
//   step_req     : (feature) per-channel single-step while paused
//   clk_en       : registered per-channel enable pulses
//   sync_rst     : registered active-high synchronous reset
//   rst_done     : one-cycle pulse on the first run cycle
//   dbg_state    : current sequencing state, for observation only
// There is no valid/ready handshake: every output is a registered level or
// pulse that is meaningful on every clock cycle.
module clk_domain_ctrl
    import clk_domain_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int DIV_W           = DEF_DIV_W,
    parameter int RST_SYNC_STAGES = DEF_RST_SYNC_STAGES,
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES
) (
    input  logic                        clk,
    input  logic                        async_rst,
    input  logic                        soft_rst_req,
    input  logic [NUM_CH-1:0]           ch_run,
    input  logic [NUM_CH-1:0][DIV_W-1:0] ch_div,
`ifdef CLK_DOMAIN_CTRL_STEP_EN
    input  logic [NUM_CH-1:0]           step_req,
`endif
    output logic [NUM_CH-1:0]           clk_en,
    output logic                        sync_rst,
    output logic                        rst_done,
    output rst_state_t                  dbg_state
);

    localparam int HOLD_W = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [RST_SYNC_STAGES-1:0] sync_ff;
    logic                       rst_released;
    rst_state_t                 state, next_state;
    logic [HOLD_W-1:0]          hold_cnt;
    logic                       sync_rst_d, rst_done_d, ch_force, ch_active;

    // Release synchroniser: assertion clears at once, 1s shift in on release.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) sync_ff <= '0;
        else            sync_ff <= {sync_ff[RST_SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_released = sync_ff[RST_SYNC_STAGES-1];

    // State register and hold counter.
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            state    <= S_ASSERT;
            hold_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_HOLD && (state != S_HOLD || soft_rst_req))
                hold_cnt <= '0;
            else if (state == S_HOLD)
                hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Next-state logic. hold_cnt counts hold cycles already completed minus
    // one, so HOLD_LAST marks the final cycle of the hold window.
    always_comb begin
        next_state = state;
        unique case (state)
            S_ASSERT: if (rst_released) next_state = S_HOLD;
            S_HOLD: begin
                if (soft_rst_req)             next_state = S_HOLD;
                else if (hold_cnt == HOLD_LAST) next_state = S_RUN;
            end
            S_RUN:    if (soft_rst_req) next_state = S_HOLD;
            default:  next_state = S_ASSERT;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the state they describe.
    always_comb begin
        sync_rst_d = (next_state != S_RUN);
        rst_done_d = (next_state == S_RUN) && (state != S_RUN);
        ch_force   = (next_state == S_HOLD);
        ch_active  = (state == S_RUN) && (next_state == S_RUN);
    end

    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            sync_rst <= 1'b1;
            rst_done <= 1'b0;
        end else begin
            sync_rst <= sync_rst_d;
            rst_done <= rst_done_d;
        end
    end

    assign dbg_state = state;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_divider #(.DIV_W(DIV_W)) u_div (
            .clk       (clk),
            .async_rst (async_rst),
            .force_on  (ch_force),
            .active    (ch_active),
            .run       (ch_run[i]),
            .div       (ch_div[i]),
`ifdef CLK_DOMAIN_CTRL_STEP_EN
            .step      (step_req[i]),
`endif
            .clk_en    (clk_en[i])
        );
    end

endmodule

// File: doc/clk_domain_ctrl.md
Name: clk_domain_ctrl

Overview:
Parametrised successor to the system clock-domain manager. Runs on the free-running reference clock and synchronises the asynchronous active-low reset. It sequences a stretched synchronous reset (sync_rst) and drives NUM_CH independent clock-enable channels, each with a programmable divide ratio and run/pause control. It sits at the top level between the board reset/clock and the CPU and peripheral enable gating.

Parameters:
NUM_CH, 2, number of clock-enable channels (1..8)
DIV_W, 16, width of each channel's divide-ratio field
RST_SYNC_STAGES, 2, flops in the reset-deassert synchroniser (>=2)
RST_HOLD_CYCLES, 16, cycles sync_rst stays high after sync release or soft reset (>=1)

Ports:
clk  in  1  free-running reference clock; all state on rising edge
async_rst  in  1  asynchronous active-low reset; assertion immediate, deassertion synchronised internally
soft_rst_req  in  1  synchronous request, high one or more cycles; restarts the reset-hold sequence
ch_run  in  NUM_CH  per-channel run (1) / pause (0)
ch_div  in  NUM_CH x DIV_W  per-channel divide value D; enable period = D+1 cycles
clk_en  out  NUM_CH  registered per-channel clock-enable pulses
sync_rst  out  1  registered active-high synchronous reset for downstream logic
rst_done  out  1  one-cycle pulse on the first RUN cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `async_rst` is asynchronous, active-low (fixed).
- async_rst low, immediately: sync chain cleared, state=S_ASSERT, all counters 0, clk_en=0, sync_rst=1, rst_done=0.
- Deassert synchroniser: async_rst high shifts 1s through RST_SYNC_STAGES flops. Synchronised release = last stage high.
- FSM, package enum:
  - S_ASSERT: sync_rst=1, clk_en=0. On synchronised release -> S_HOLD, hold_cnt<=0.
  - S_HOLD: sync_rst=1, clk_en = all ones, so synchronous-reset flops behind gated clocks see edges. hold_cnt increments. After exactly RST_HOLD_CYCLES cycles in S_HOLD -> S_RUN.
  - S_RUN: sync_rst=0; channels operate. rst_done=1 only in the first S_RUN cycle.
- soft_rst_req=1 in S_HOLD or S_RUN -> S_HOLD next edge, hold_cnt<=0. Repeated requests in S_HOLD restart the count. Ignored in S_ASSERT. async_rst low overrides everything.
- Channel i in S_RUN, evaluated on each edge:
  - Entering S_RUN: cnt<=0, clk_en<=0.
  - ch_run=1 and cnt==0: clk_en<=1, cnt<=ch_div[i].
  - ch_run=1 and cnt!=0: clk_en<=0, cnt<=cnt-1.
  - ch_run=0: clk_en<=0, cnt held, so phase resumes on re-run.
- Channel timing:
  - First clk_en pulse is in the 2nd S_RUN cycle. Thereafter one pulse every D+1 cycles.
  - D=0 gives clk_en continuously high.
  - D = 2^DIV_W-1 gives maximum period with no overflow; unsigned arithmetic throughout.
  - A ch_div change takes effect at the next reload only.
- Leaving S_RUN (soft reset): clk_en forced all ones from the next cycle (S_HOLD rule). Counters reset to 0 on re-entry to S_RUN.
- All outputs registered; no combinational input->output paths.

Optional Feature:
CLK_DOMAIN_CTRL_STEP_EN
- Defined:
  - Adds input step_req[NUM_CH].
  - In S_RUN with ch_run[i]=0, step_req[i]=1 gives clk_en[i]=1 for exactly one cycle on the next edge. cnt is unchanged.
  - Held step_req yields one pulse per cycle it is high.
  - Ignored when ch_run[i]=1 or outside S_RUN.
- Undefined: port absent; paused channels produce no pulses.

Decomposition:
- Package clk_domain_pkg:
  - typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RUN} rst_state_t
  - default constants for DIV_W, RST_HOLD_CYCLES, RST_SYNC_STAGES
- Sub-module clk_en_divider:
  - one channel: cnt, reload, run/pause, optional step
  - instantiated NUM_CH times via generate
- Reset sync and FSM stay in the top module.

Test Plan:
- Release: async_rst 0->1 with RST_SYNC_STAGES=2, RST_HOLD_CYCLES=16 -> sync_rst high for 2 sync cycles + 16 hold cycles. clk_en=2'b11 during hold. rst_done pulses once, then sync_rst=0.
- Divider: ch_div[0]=3, ch_div[1]=0, ch_run=2'b11 -> clk_en[0] high in RUN cycles 2, 6, 10. clk_en[1] high from RUN cycle 2 onward continuously.
- Pause/resume: ch_div[0]=4, drop ch_run[0] for 7 cycles mid-count -> clk_en[0]=0 throughout the pause. Phase resumes with the remaining count, no extra pulse.
- Soft reset: soft_rst_req for 1 cycle in RUN -> next cycle sync_rst=1 and clk_en all ones for 16 cycles. Second request at hold cycle 10 extends the hold to 26 total.
- Async mid-operation: async_rst low during RUN -> clk_en=0, sync_rst=1 same cycle (asynchronous). Full sequence repeats on release.
- STEP_EN build: ch_run[0]=0, step_req[0] pulsed 3 single cycles -> exactly 3 single-cycle clk_en[0] pulses. step_req with ch_run=1 -> no extra pulses.
